bcd_serial_subtractor: RTL and testbench

//   Digit-serial packed-BCD subtractor: computes DIFF = A - B over DIGITS decimal

---
 rtl/bcd_serial_subtractor_if.sv | 24 ++
 rtl/bcd_serial_subtractor.sv | 121 ++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bus for the digit-serial BCD subtractor.
// The master launches an operation; the slave (the subtractor) returns status and result.
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  borrow_out;
  logic                  err;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, err
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: DIFF = A - B, one decimal digit per clock,
// least significant digit first. Negative results come out in ten's complement
// with borrow_out set; any operand digit above 9 flags err and zeroes the result.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_serial_subtractor_if.slave bus
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     acc_reg;      // partial result, hidden until DONE
  logic [IDX_W-1:0] idx_reg;
  logic             br_reg;
  logic             err_acc_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [W-1:0]     diff_reg;
  logic             borrow_reg;
  logic             err_reg;

  // Per-digit validity of the incoming operands, evaluated at launch time.
  logic [DIGITS-1:0] a_bad;
  logic [DIGITS-1:0] b_bad;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit_check
      assign a_bad[gi] = (bus.a[4*gi +: 4] > 4'd9);
      assign b_bad[gi] = (bus.b[4*gi +: 4] > 4'd9);
    end
  endgenerate

  // One digit of the borrow chain: 5-bit signed difference, corrected by +10 on borrow.
  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [4:0] t_next;
  logic [3:0] digit_next;
  logic       br_next;

  // Select the current digit pair and compute the corrected digit and outgoing borrow.
  always_comb begin
    a_dig      = a_reg[4*idx_reg +: 4];
    b_dig      = b_reg[4*idx_reg +: 4];
    t_next     = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, br_reg};
    br_next    = t_next[4];
    digit_next = br_next ? (t_next[3:0] + 4'd10) : t_next[3:0];
  end

  // Control FSM with registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      idx_reg     <= '0;
      br_reg      <= 1'b0;
      err_acc_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      diff_reg    <= '0;
      borrow_reg  <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg       <= bus.a;
            b_reg       <= bus.b;
            acc_reg     <= '0;
            idx_reg     <= '0;
            br_reg      <= 1'b0;
            err_acc_reg <= (|a_bad) | (|b_bad);
            busy_reg    <= 1'b1;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          acc_reg[4*idx_reg +: 4] <= digit_next;
          br_reg                  <= br_next;
          idx_reg                 <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg   <= 1'b1;
          err_reg    <= err_acc_reg;
          diff_reg   <= err_acc_reg ? '0 : acc_reg;
          borrow_reg <= err_acc_reg ? 1'b0 : br_reg;
          state_reg  <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.diff       = diff_reg;
  assign bus.borrow_out = borrow_reg;
  assign bus.err        = err_reg;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor: directed vectors, random operands
// against a decimal-arithmetic reference, handshake timing, ignored start and reset abort.
module tb_bcd_serial_subtractor;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus_if ();

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decode operands as decimal integers, subtract, re-encode.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic bo, output logic er);
    int va, vb, vd, m;
    logic [3:0] na, nb;
    va = 0; vb = 0; m = 1; er = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      if (na > 4'd9 || nb > 4'd9) er = 1'b1;
      va += int'(na) * m;
      vb += int'(nb) * m;
      m  *= 10;
    end
    vd = va - vb;
    bo = (vd < 0);
    if (bo) vd += m;
    d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d[4*i +: 4] = 4'(vd % 10);
      vd = vd / 10;
    end
    if (er) begin
      d  = '0;
      bo = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    int bad_pos;
    v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 7) == 0)) begin
      bad_pos = $urandom_range(0, DIGITS - 1);
      v[4*bad_pos +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  // Launch one operation from the current negedge and observe it until done.
  // extra_at >= 0 re-pulses start (with new operands) that many cycles after launch.
  // lat = cycles from the launch edge to the done cycle; -1 if done never came.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int extra_at,
                       output int busy_cnt, output int lat,
                       output logic [W-1:0] d, output logic bo, output logic er);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    @(negedge clk);
    busy_cnt = 0;
    lat      = -1;
    d        = '0;
    bo       = 1'b0;
    er       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus_if.start = (i == extra_at);
      bus_if.a     = rand_bcd(1'b0);
      bus_if.b     = rand_bcd(1'b0);
      if (bus_if.done === 1'b1) begin
        lat = i;
        d   = bus_if.diff;
        bo  = bus_if.borrow_out;
        er  = bus_if.err;
        break;
      end
      if (bus_if.busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    bus_if.start = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.start = 1'b1;
    bus_if.a     = 16'h4321;
    bus_if.b     = 16'h1234;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.diff !== '0 ||
        bus_if.borrow_out !== 1'b0 || bus_if.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b err=%b, required all 0",
               bus_if.busy, bus_if.done, bus_if.diff, bus_if.borrow_out, bus_if.err);
    end
    $display("reset: busy=%b done=%b diff=%h", bus_if.busy, bus_if.done, bus_if.diff);
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] d, ed;
    logic bo, er, ebo, eer;
    int bc, lat;
    va[0] = 16'h4321; vb[0] = 16'h1234;
    va[1] = 16'h0000; vb[1] = 16'h0001;
    va[2] = 16'h5000; vb[2] = 16'h5000;
    va[3] = 16'h12A3; vb[3] = 16'h0001;
    for (int k = 0; k < 4; k++) begin
      model(va[k], vb[k], ed, ebo, eer);
      do_op(va[k], vb[k], -1, bc, lat, d, bo, er);
      checks++;
      if (bc != DIGITS || lat != DIGITS + 1) begin
        errors++;
        $display("FAIL vec%0d_timing: busy_cycles=%0d done_latency=%0d, required %0d and %0d",
                 k, bc, lat, DIGITS, DIGITS + 1);
      end
      checks++;
      if (d !== ed || bo !== ebo || er !== eer) begin
        errors++;
        $display("FAIL vec%0d_result: diff=%h borrow=%b err=%b, required diff=%h borrow=%b err=%b",
                 k, d, bo, er, ed, ebo, eer);
      end
      $display("vec%0d: a=%h b=%h -> diff=%h borrow=%b err=%b", k, va[k], vb[k], d, bo, er);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, d, ed;
    logic bo, er, ebo, eer;
    int bc, lat;
    for (int k = 0; k < 30; k++) begin
      a = rand_bcd(1'b1);
      b = rand_bcd(1'b1);
      model(a, b, ed, ebo, eer);
      do_op(a, b, -1, bc, lat, d, bo, er);
      checks++;
      if (lat != DIGITS + 1 || d !== ed || bo !== ebo || er !== eer) begin
        errors++;
        $display("FAIL rand%0d: a=%h b=%h lat=%0d diff=%h borrow=%b err=%b, required lat=%0d diff=%h borrow=%b err=%b",
                 k, a, b, lat, d, bo, er, DIGITS + 1, ed, ebo, eer);
      end
      $display("rand%0d: a=%h b=%h -> diff=%h borrow=%b err=%b", k, a, b, d, bo, er);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, d, ed;
    logic bo, er, ebo, eer;
    int bc, lat;
    // Each launch happens in the very cycle the previous done is visible.
    for (int k = 0; k < 4; k++) begin
      a = rand_bcd(1'b0);
      b = rand_bcd(1'b0);
      model(a, b, ed, ebo, eer);
      do_op(a, b, -1, bc, lat, d, bo, er);
      checks++;
      if (bc != DIGITS || lat != DIGITS + 1 || d !== ed || bo !== ebo || er !== eer) begin
        errors++;
        $display("FAIL b2b%0d: busy=%0d lat=%0d diff=%h borrow=%b err=%b, required busy=%0d lat=%0d diff=%h borrow=%b err=%b",
                 k, bc, lat, d, bo, er, DIGITS, DIGITS + 1, ed, ebo, eer);
      end
      $display("b2b%0d: a=%h b=%h -> diff=%h borrow=%b", k, a, b, d, bo);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] d, ed;
    logic bo, er, ebo, eer;
    int bc, lat, extra_done;
    model(16'h0000, 16'h0001, ed, ebo, eer);
    do_op(16'h0000, 16'h0001, 2, bc, lat, d, bo, er);
    checks++;
    if (lat != DIGITS + 1 || d !== ed || bo !== ebo || er !== eer) begin
      errors++;
      $display("FAIL ignore_start_result: lat=%0d diff=%h borrow=%b, required lat=%0d diff=%h borrow=%b",
               lat, d, bo, DIGITS + 1, ed, ebo);
    end
    extra_done = 0;
    for (int i = 0; i < 2 * DIGITS + 4; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL ignore_start_single_done: extra busy/done cycles=%0d, required 0", extra_done);
    end
    $display("ignore_start: diff=%h borrow=%b extra_activity=%0d", d, bo, extra_done);
  endtask

  task automatic test_reset_run();
    logic [W-1:0] d, ed;
    logic bo, er, ebo, eer;
    int bc, lat, seen;
    do_op(16'h9000, 16'h0001, -1, bc, lat, d, bo, er);   // leaves nonzero outputs
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 16'h0000;
    bus_if.b     = 16'h0001;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.diff !== '0 ||
        bus_if.borrow_out !== 1'b0 || bus_if.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_run_clear: busy=%b done=%b diff=%h borrow=%b err=%b, required all 0",
               bus_if.busy, bus_if.done, bus_if.diff, bus_if.borrow_out, bus_if.err);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_run_no_done: activity cycles=%0d, required 0", seen);
    end
    model(16'h4321, 16'h1234, ed, ebo, eer);
    do_op(16'h4321, 16'h1234, -1, bc, lat, d, bo, er);
    checks++;
    if (bc != DIGITS || lat != DIGITS + 1 || d !== ed || bo !== ebo || er !== eer) begin
      errors++;
      $display("FAIL reset_run_fresh: busy=%0d lat=%0d diff=%h borrow=%b err=%b, required busy=%0d lat=%0d diff=%h borrow=%b err=%b",
               bc, lat, d, bo, er, DIGITS, DIGITS + 1, ed, ebo, eer);
    end
    $display("reset_run: fresh diff=%h borrow=%b", d, bo);
    @(negedge clk);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
